code_change_controller: RTL and testbench

- Sequences the code-change flow of the safe: verify current code, enter new code, re-enter new code to confirm, commit to the stored code register.
- Drives the entry shift register (clear_entry, accept_digit) and the stored code register (load_code, new_code).
- Enforces an inactivity timeout and a failed-attempt lockout.
- Sits beside safe_controller_fsm; the top level muxes its shift-register controls in while busy is high.

---
 rtl/code_change_controller.sv | 145 ++++++++++++++
 tb/tb_code_change_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_change_controller.sv
// Code-change sequencer for the safe: verifies the current code, collects and
// confirms a new one, then commits it, with inactivity timeout and fail lockout.
module code_change_controller #(
  parameter int CODE_W         = 16,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              change_req,
  input  logic              abort,
  input  logic              digit_valid,
  input  logic              done,
  input  logic [CODE_W-1:0] entered_code,
  input  logic [CODE_W-1:0] stored_code,
  output logic              clear_entry,
  output logic              accept_digit,
  output logic              load_code,
  output logic [CODE_W-1:0] new_code,
  output logic              busy,
  output logic              locked_out,
  output logic              result_valid,
  output logic [1:0]        result,
  output logic [3:0]        fail_count
);

  typedef enum logic [3:0] {
    IDLE, CLR_OLD, GET_OLD, CHK_OLD, CLR_N1, GET_N1, CLR_N2, GET_N2,
    CHK_NEW, COMMIT, MISMATCH, LOCKOUT, QUIT
  } state_t;

  localparam logic [1:0] RES_OK   = 2'b01;
  localparam logic [1:0] RES_MISM = 2'b10;
  localparam logic [1:0] RES_QUIT = 2'b11;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LK_LAST = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]    FAIL_LIM = 4'(MAX_FAILS);

  state_t            state_q, state_d;
  logic [TW-1:0]     idle_q;
  logic [LW-1:0]     lock_q;
  logic [CODE_W-1:0] hold_q;
  logic [1:0]        result_q;
  logic [3:0]        fail_q;
  logic              in_get;
  logic              timeout;

  assign in_get  = (state_q == GET_OLD) || (state_q == GET_N1) || (state_q == GET_N2);
  // The timer reads TIMEOUT_CYCLES-1 on the last allowed idle cycle, so the
  // exit lands exactly TIMEOUT_CYCLES edges after the last digit.
  assign timeout = in_get && !digit_valid && (idle_q >= TO_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (change_req) state_d = CLR_OLD;
      CLR_OLD:  state_d = GET_OLD;
      CLR_N1:   state_d = GET_N1;
      CLR_N2:   state_d = GET_N2;
      GET_OLD:  if (done) state_d = CHK_OLD; else if (timeout) state_d = QUIT;
      GET_N1:   if (done) state_d = CLR_N2;  else if (timeout) state_d = QUIT;
      GET_N2:   if (done) state_d = CHK_NEW; else if (timeout) state_d = QUIT;
      CHK_OLD:  state_d = (entered_code == stored_code) ? CLR_N1 : MISMATCH;
      CHK_NEW:  state_d = (entered_code == hold_q) ? COMMIT : MISMATCH;
      COMMIT:   state_d = IDLE;
      MISMATCH: state_d = (fail_q >= FAIL_LIM) ? LOCKOUT : IDLE;
      LOCKOUT:  if (lock_q >= LK_LAST) state_d = IDLE;
      QUIT:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // A commit in flight always completes; lockout cannot be cut short.
    if (abort && !(state_q inside {IDLE, LOCKOUT, COMMIT, QUIT}))
      state_d = QUIT;
  end

  always_comb begin
    clear_entry  = 1'b0;
    accept_digit = 1'b0;
    load_code    = 1'b0;
    locked_out   = 1'b0;
    result_valid = 1'b0;
    busy         = (state_q != IDLE);
    unique case (state_q)
      CLR_OLD, CLR_N1, CLR_N2: clear_entry = 1'b1;
      GET_OLD, GET_N1, GET_N2: accept_digit = 1'b1;
      COMMIT:   begin load_code = 1'b1; result_valid = 1'b1; end
      MISMATCH: result_valid = 1'b1;
      LOCKOUT:  locked_out = 1'b1;
      QUIT:     begin clear_entry = 1'b1; result_valid = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
      lock_q <= '0;
    end else begin
      if (!in_get || digit_valid) idle_q <= '0;
      else if (idle_q < TO_LAST)  idle_q <= idle_q + 1'b1;
      if (state_q != LOCKOUT)     lock_q <= '0;
      else if (lock_q < LK_LAST)  lock_q <= lock_q + 1'b1;
    end
  end

  // Result and fail count update on entry to the reporting state so they are
  // already valid while result_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      result_q <= 2'b00;
      fail_q   <= 4'd0;
    end else begin
      if (state_q == GET_N1 && state_d == CLR_N2) hold_q <= entered_code;
      if (state_d == COMMIT) begin
        result_q <= RES_OK;
        fail_q   <= 4'd0;
      end else if (state_d == MISMATCH) begin
        result_q <= RES_MISM;
        if (fail_q != 4'hF) fail_q <= fail_q + 4'd1;
      end else if (state_d == QUIT) begin
        result_q <= RES_QUIT;
      end else if (state_q == LOCKOUT && state_d == IDLE) begin
        fail_q <= 4'd0;
      end
    end
  end

  assign new_code   = hold_q;
  assign result     = result_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_code_change_controller.sv
// Directed bench for code_change_controller; models the keypad shift register
// and the stored code register around the DUT.
module tb_code_change_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        change_req = 1'b0, abort = 1'b0, digit_valid = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        done;
  logic [15:0] entered_code, stored_code, new_code;
  logic        clear_entry, accept_digit, load_code, busy, locked_out, result_valid;
  logic [1:0]  result;
  logic [3:0]  fail_count;
  logic [15:0] sr;
  logic [2:0]  cnt;
  logic [27:0] outs;
  int          total = 0, bad = 0, load_cnt = 0;

  always #5 clk = ~clk;

  code_change_controller #(
    .CODE_W(16), .MAX_FAILS(3), .LOCKOUT_CYCLES(8), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .change_req(change_req), .abort(abort),
    .digit_valid(digit_valid), .done(done), .entered_code(entered_code),
    .stored_code(stored_code), .clear_entry(clear_entry), .accept_digit(accept_digit),
    .load_code(load_code), .new_code(new_code), .busy(busy), .locked_out(locked_out),
    .result_valid(result_valid), .result(result), .fail_count(fail_count)
  );

  // Keypad entry shift register and stored code register around the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= 16'h0; cnt <= 3'd0; stored_code <= 16'h1234;
    end else begin
      if (clear_entry) begin
        sr <= 16'h0; cnt <= 3'd0;
      end else if (accept_digit && digit_valid && cnt < 3'd4) begin
        sr <= {sr[11:0], digit}; cnt <= cnt + 3'd1;
      end
      if (load_code) stored_code <= new_code;
    end
  end
  always @(posedge clk) if (rst_n && load_code) load_cnt <= load_cnt + 1;

  assign done = (cnt == 3'd4);
  assign entered_code = sr;
  assign outs = {clear_entry, accept_digit, load_code, busy, locked_out,
                 result_valid, result, fail_count, new_code};

  task automatic do_reset();
    rst_n = 1'b0; change_req = 1'b0; abort = 1'b0; digit_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_flow();
    change_req = 1'b1;
    @(negedge clk);
    change_req = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] d);
    digit = d; digit_valid = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(accept_digit && cnt == 3'd0) && n < 50) begin @(negedge clk); n++; end
    total++;
    if (!(accept_digit && cnt == 3'd0)) begin
      $display("FAIL wait_ready: accept_digit=%b cnt=%0d want accept with empty entry", accept_digit, cnt);
      bad++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL wait_idle: busy=%b want 0", busy);
      bad++;
    end
  endtask

  task automatic enter_code(input logic [15:0] c);
    wait_ready();
    for (int i = 3; i >= 0; i--) send_digit(c[i*4 +: 4]);
  endtask

  task automatic wrong_flow();
    start_flow();
    enter_code(16'h9999);
    wait_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (outs !== 28'h0) begin $display("FAIL reset_outs: got %h want 0", outs); bad++; end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin $display("FAIL reset_idle: busy=%b want 0", busy); bad++; end
  endtask

  task automatic test_happy();
    int lc0;
    do_reset(); lc0 = load_cnt;
    start_flow();
    total++;
    if ({clear_entry, accept_digit} !== 2'b10) begin
      $display("FAIL happy_clr_old: clear/accept=%b want 10", {clear_entry, accept_digit}); bad++;
    end
    @(negedge clk);
    total++;
    if (accept_digit !== 1'b1) begin $display("FAIL happy_latency: accept=%b want 1", accept_digit); bad++; end
    enter_code(16'h1234); enter_code(16'h5678); enter_code(16'h5678);
    @(negedge clk);
    total++;
    if (load_code !== 1'b0) begin $display("FAIL happy_early_load: load=%b want 0", load_code); bad++; end
    @(negedge clk);
    total++;
    if ({load_code, result_valid, result, fail_count, new_code} !== {1'b1, 1'b1, 2'b01, 4'd0, 16'h5678}) begin
      $display("FAIL happy_commit: load=%b rv=%b res=%b fc=%0d nc=%h want 1 1 01 0 5678",
               load_code, result_valid, result, fail_count, new_code); bad++;
    end
    @(negedge clk);
    total++;
    if ({busy, load_code, stored_code} !== {1'b0, 1'b0, 16'h5678} || load_cnt - lc0 != 1) begin
      $display("FAIL happy_after: busy=%b load=%b stored=%h loads=%0d want 0 0 5678 1",
               busy, load_code, stored_code, load_cnt - lc0); bad++;
    end
  endtask

  task automatic test_abort_in_commit();
    do_reset();
    start_flow();
    enter_code(16'h1234); enter_code(16'h5678); enter_code(16'h5678);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({busy, clear_entry, result_valid, result, stored_code} !== {1'b0, 1'b0, 1'b0, 2'b01, 16'h5678}) begin
      $display("FAIL abort_commit: busy=%b clr=%b rv=%b res=%b stored=%h want 0 0 0 01 5678",
               busy, clear_entry, result_valid, result, stored_code); bad++;
    end
  endtask

  task automatic test_wrong_old();
    int lc0;
    do_reset(); lc0 = load_cnt;
    start_flow();
    enter_code(16'h9999);
    repeat (2) @(negedge clk);
    total++;
    if ({result_valid, result, fail_count, load_code} !== {1'b1, 2'b10, 4'd1, 1'b0}) begin
      $display("FAIL wrong_old: rv=%b res=%b fc=%0d load=%b want 1 10 1 0",
               result_valid, result, fail_count, load_code); bad++;
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || load_cnt != lc0) begin
      $display("FAIL wrong_old_idle: busy=%b loads=%0d want 0 0", busy, load_cnt - lc0); bad++;
    end
  endtask

  task automatic test_confirm_mismatch();
    int lc0;
    do_reset(); lc0 = load_cnt;
    start_flow();
    enter_code(16'h1234); enter_code(16'h5678); enter_code(16'h5679);
    repeat (2) @(negedge clk);
    total++;
    if ({result_valid, result, fail_count, new_code} !== {1'b1, 2'b10, 4'd1, 16'h5678}) begin
      $display("FAIL confirm_mism: rv=%b res=%b fc=%0d nc=%h want 1 10 1 5678",
               result_valid, result, fail_count, new_code); bad++;
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || stored_code !== 16'h1234 || load_cnt != lc0) begin
      $display("FAIL confirm_mism_after: busy=%b stored=%h loads=%0d want 0 1234 0",
               busy, stored_code, load_cnt - lc0); bad++;
    end
  endtask

  task automatic test_lockout();
    int n = 0;
    do_reset();
    wrong_flow(); wrong_flow();
    total++;
    if (fail_count !== 4'd2) begin $display("FAIL lockout_pre: fc=%0d want 2", fail_count); bad++; end
    start_flow();
    enter_code(16'h9999);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      if (locked_out) n++;
      change_req = (i == 2);
      abort = (i == 4);
      @(negedge clk);
    end
    total++;
    if (n != 8) begin $display("FAIL lockout_len: cycles=%0d want 8", n); bad++; end
    total++;
    if ({busy, locked_out, fail_count, result} !== {1'b0, 1'b0, 4'd0, 2'b10}) begin
      $display("FAIL lockout_exit: busy=%b lo=%b fc=%0d res=%b want 0 0 0 10",
               busy, locked_out, fail_count, result); bad++;
    end
  endtask

  task automatic test_timeout();
    int k = 0;
    do_reset();
    wrong_flow();
    start_flow();
    wait_ready();
    send_digit(4'd1); send_digit(4'd2);
    while (!clear_entry && k < 100) begin @(negedge clk); k++; end
    total++;
    if (k != 20) begin $display("FAIL timeout_len: cycles=%0d want 20", k); bad++; end
    total++;
    if ({result_valid, result, fail_count, accept_digit} !== {1'b1, 2'b11, 4'd1, 1'b0}) begin
      $display("FAIL timeout_quit: rv=%b res=%b fc=%0d acc=%b want 1 11 1 0",
               result_valid, result, fail_count, accept_digit); bad++;
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin $display("FAIL timeout_idle: busy=%b want 0", busy); bad++; end
  endtask

  task automatic test_abort_n2();
    int lc0;
    do_reset(); lc0 = load_cnt;
    start_flow();
    enter_code(16'h1234); enter_code(16'h5678);
    wait_ready();
    send_digit(4'd5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({clear_entry, result_valid, result, load_code, fail_count} !== {1'b1, 1'b1, 2'b11, 1'b0, 4'd0}) begin
      $display("FAIL abort_n2: clr=%b rv=%b res=%b load=%b fc=%0d want 1 1 11 0 0",
               clear_entry, result_valid, result, load_code, fail_count); bad++;
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || stored_code !== 16'h1234 || load_cnt != lc0) begin
      $display("FAIL abort_n2_after: busy=%b stored=%h loads=%0d want 0 1234 0",
               busy, stored_code, load_cnt - lc0); bad++;
    end
  endtask

  task automatic test_reset_mid_flow();
    int lc0;
    do_reset();
    start_flow();
    enter_code(16'h1234); enter_code(16'h5678); enter_code(16'h5678);
    wait_idle();
    wrong_flow();
    start_flow();
    enter_code(16'h5678);
    wait_ready();
    send_digit(4'd1); send_digit(4'd2);
    lc0 = load_cnt;
    total++;
    if ({busy, accept_digit, fail_count, new_code} !== {1'b1, 1'b1, 4'd1, 16'h5678}) begin
      $display("FAIL rst_pre: busy=%b acc=%b fc=%0d nc=%h want 1 1 1 5678",
               busy, accept_digit, fail_count, new_code); bad++;
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (outs !== 28'h0) begin $display("FAIL rst_async: got %h want 0", outs); bad++; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || load_cnt != lc0 || fail_count !== 4'd0) begin
      $display("FAIL rst_after: busy=%b loads=%0d fc=%0d want 0 0 0", busy, load_cnt - lc0, fail_count); bad++;
    end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_abort_in_commit();
    test_wrong_old();
    test_confirm_mismatch();
    test_lockout();
    test_timeout();
    test_abort_n2();
    test_reset_mid_flow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
